// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, PC/ALU selects and FSM states.
package mc_pkg;

  localparam logic [3:0] OpNop  = 4'h0;
  localparam logic [3:0] OpSt   = 4'h3;
  localparam logic [3:0] OpAdd  = 4'h4;
  localparam logic [3:0] OpAddi = 4'h5;
  localparam logic [3:0] OpNeg  = 4'h6;
  localparam logic [3:0] OpSub  = 4'h7;
  localparam logic [3:0] OpJ    = 4'h8;
  localparam logic [3:0] OpBrz  = 4'h9;
  localparam logic [3:0] OpJm   = 4'hA;
  localparam logic [3:0] OpBrn  = 4'hB;
  localparam logic [3:0] OpLd   = 4'hE;
  localparam logic [3:0] OpSvpc = 4'hF;

  localparam logic [1:0] PcInc    = 2'd0;
  localparam logic [1:0] PcJump   = 2'd1;
  localparam logic [1:0] PcBranch = 2'd2;
  localparam logic [1:0] PcMem    = 2'd3;

  localparam logic [2:0] AluNone = 3'b000;
  localparam logic [2:0] AluAdd  = 3'b100;
  localparam logic [2:0] AluNeg  = 3'b010;
  localparam logic [2:0] AluSub  = 3'b001;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb
  } state_e;

endpackage

// File: rtl/mc_tmo.sv
// Memory request timeout counter; expired flags the TMO-th consecutive unacknowledged cycle.
module mc_tmo #(
  parameter int unsigned TMO = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TMO + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = en && (cnt_q == CW'(TMO - 1));

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing over a req/ack memory,
// with internal Z/N flags, illegal-opcode and bus-timeout pulses.
module mc_ctrl
  import mc_pkg::*;
#(
  parameter int unsigned IW    = 32,
  parameter int unsigned OPW   = 4,
  parameter int unsigned OPLSB = 28,
  parameter int unsigned TMO   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] inst,
  input  logic          z,
  input  logic          n,
  input  logic          mem_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic          addr_sel,
  output logic          ir_we,
  output logic          pc_we,
  output logic [1:0]    pc_src,
  output logic          reg_we,
  output logic          wb_sel,
  output logic          alu_src,
  output logic [2:0]    alu_op,
  output logic          flag_z,
  output logic          flag_n,
  output logic          illegal,
  output logic          bus_err
);

  state_e     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic       flag_z_q, flag_z_d, flag_n_q, flag_n_d;
  logic       tmo_en, tmo_clr, tmo_expired;
  logic [OPW-1:0] inst_op;
  logic       unused_inst;

  assign inst_op     = inst[OPLSB +: OPW];
  assign unused_inst = ^inst;
  assign mem_req     = (state_q == StFetch) || (state_q == StMem);
  assign flag_z      = flag_z_q;
  assign flag_n      = flag_n_q;

  // Counter is held at zero outside unacknowledged request cycles, so every FETCH/MEM entry
  // (including a retry after timeout) starts from zero.
  assign tmo_en  = mem_req && !mem_ack;
  assign tmo_clr = !tmo_en || tmo_expired;

  mc_tmo #(
    .TMO(TMO)
  ) u_tmo (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expired(tmo_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      flag_z_q <= flag_z_d;
      flag_n_q <= flag_n_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    flag_z_d = flag_z_q;
    flag_n_d = flag_n_q;
    mem_we   = 1'b0;
    addr_sel = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    pc_src   = PcInc;
    reg_we   = 1'b0;
    wb_sel   = 1'b0;
    alu_src  = 1'b0;
    alu_op   = AluNone;
    illegal  = 1'b0;
    bus_err  = 1'b0;

    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        if (mem_ack) begin
          ir_we   = 1'b1;
          op_d    = 4'(inst_op);
          state_d = StDecode;
        end else if (tmo_expired) begin
          bus_err = 1'b1;
          state_d = StFetch;
        end
      end
      StDecode: state_d = StExec;
      StExec: begin
        state_d = StFetch;
        unique case (op_q)
          OpAdd, OpAddi, OpNeg, OpSub: begin
            alu_op   = (op_q == OpNeg) ? AluNeg : (op_q == OpSub) ? AluSub : AluAdd;
            alu_src  = (op_q == OpAddi);
            flag_z_d = z;
            flag_n_d = n;
            state_d  = StWb;
          end
          OpSvpc: begin
            alu_op  = AluAdd;
            alu_src = 1'b1;
            state_d = StWb;
          end
          OpLd, OpSt, OpJm: begin
            alu_op  = AluAdd;
            state_d = StMem;
          end
          OpJ: begin
            pc_we  = 1'b1;
            pc_src = PcJump;
          end
          OpBrz: begin
            pc_we  = 1'b1;
            pc_src = flag_z_q ? PcBranch : PcInc;
          end
          OpBrn: begin
            pc_we  = 1'b1;
            pc_src = flag_n_q ? PcBranch : PcInc;
          end
          OpNop: pc_we = 1'b1;
          default: begin
            illegal = 1'b1;
            pc_we   = 1'b1;
          end
        endcase
      end
      StMem: begin
        addr_sel = 1'b1;
        mem_we   = (op_q == OpSt);
        if (mem_ack) begin
          if (op_q == OpLd) begin
            state_d = StWb;
          end else begin
            pc_we   = 1'b1;
            pc_src  = (op_q == OpJm) ? PcMem : PcInc;
            state_d = StFetch;
          end
        end else if (tmo_expired) begin
          bus_err = 1'b1;
          state_d = StFetch;
        end
      end
      StWb: begin
        reg_we  = 1'b1;
        wb_sel  = (op_q == OpLd);
        pc_we   = 1'b1;
        state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed vector table, hand-written timeout/reset
// sequences and randomized instructions against a per-instruction reference model.
module tb_mc_ctrl;

  localparam int TMO = 4;

  logic        clk, rst, z, n, mem_ack;
  logic [31:0] inst;
  logic        mem_req, mem_we, addr_sel, ir_we, pc_we, reg_we, wb_sel, alu_src;
  logic        flag_z, flag_n, illegal, bus_err;
  logic [1:0]  pc_src;
  logic [2:0]  alu_op;
  logic [15:0] outs;

  assign outs = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, reg_we, wb_sel, alu_src,
                 alu_op, flag_z, flag_n, illegal, bus_err};

  mc_ctrl #(
    .IW   (32),
    .OPW  (4),
    .OPLSB(28),
    .TMO  (TMO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .inst    (inst),
    .z       (z),
    .n       (n),
    .mem_ack (mem_ack),
    .mem_req (mem_req),
    .mem_we  (mem_we),
    .addr_sel(addr_sel),
    .ir_we   (ir_we),
    .pc_we   (pc_we),
    .pc_src  (pc_src),
    .reg_we  (reg_we),
    .wb_sel  (wb_sel),
    .alu_src (alu_src),
    .alu_op  (alu_op),
    .flag_z  (flag_z),
    .flag_n  (flag_n),
    .illegal (illegal),
    .bus_err (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mz = 0;
  int mn = 0;

  // Per-instruction observation summary; counts of strobes plus captured selects.
  typedef struct {
    int cyc, src, rw, wbs, ill, mw, memcyc, alu, asrc, fz, fn, be, irwe;
  } res_t;

  typedef struct {
    int   op, fd, md, z, n;
    res_t e;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic res_t mk(input int cyc, src, rw, wbs, ill, mw, memcyc, alu, asrc, fz, fn,
                              be);
    res_t r;
    r.cyc = cyc;  r.src = src;   r.rw = rw;     r.wbs = wbs;   r.ill = ill;   r.mw = mw;
    r.memcyc = memcyc; r.alu = alu; r.asrc = asrc; r.fz = fz; r.fn = fn; r.be = be;
    r.irwe = 1;
    return r;
  endfunction

  // Expected outcome from the instruction-level rules: latency table, PC source, flag semantics.
  function automatic res_t model(input int op, fd, md, zz, nn);
    res_t r;
    bit   is_alu = op inside {4, 5, 6, 7};
    bit   is_mem = op inside {3, 10, 14};
    r.cyc = (op == 14) ? 5 : (is_alu || is_mem || op == 15) ? 4 : 3;
    r.cyc += fd + (is_mem ? md : 0);
    r.src = (op == 8) ? 1 : (op == 9) ? (mz != 0 ? 2 : 0) : (op == 11) ? (mn != 0 ? 2 : 0) :
            (op == 10) ? 3 : 0;
    r.rw = int'(is_alu || op == 15 || op == 14);
    r.wbs = int'(op == 14);
    r.ill = int'(op inside {1, 2, 12, 13});
    r.mw = int'(op == 3);
    r.memcyc = is_mem ? md + 1 : 0;
    r.alu = (op == 6) ? 2 : (op == 7) ? 1 : (op inside {3, 4, 5, 10, 14, 15}) ? 4 : 0;
    r.asrc = int'(op == 5 || op == 15);
    r.be = fd / TMO;
    r.irwe = 1;
    if (is_alu) begin
      mz = zz;
      mn = nn;
    end
    r.fz = mz;
    r.fn = mn;
    return r;
  endfunction

  // Drives one instruction from FETCH entry to its pc_we cycle; ack arrives after fd/md waits.
  task automatic run_instr(input int op, fd, md, zz, nn, output res_t o);
    int rc = 0;
    bit ph = 0;
    bit done = 0;
    bit ack;
    o = '{default: 0};
    for (int k = 0; k < 60 && !done; k++) begin
      if (mem_req) begin
        rc++;
        ack = (rc == (ph ? md : fd) + 1);
      end else begin
        ack = 1'($urandom_range(0, 1));
      end
      mem_ack = ack;
      inst = (mem_req && !ph && ack) ? {4'(op), 28'($urandom)} : $urandom;
      z = 1'(zz);
      n = 1'(nn);
      #1;
      o.cyc++;
      if (ir_we) o.irwe++;
      if (reg_we) begin
        o.rw++;
        o.wbs = int'(wb_sel);
      end
      if (illegal) o.ill++;
      if (bus_err) o.be++;
      if (mem_req && mem_we) o.mw = 1;
      if (mem_req && addr_sel) o.memcyc++;
      o.alu = o.alu | int'(alu_op);
      if (alu_src) o.asrc = 1;
      if (mem_req && !ph && ack) begin
        ph = 1;
        rc = 0;
      end
      if (pc_we) begin
        done = 1;
        o.src = int'(pc_src);
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("pc_we within 60 cycles", 0, 1);
    mem_ack = 1'b0;
    o.fz = int'(flag_z);
    o.fn = int'(flag_n);
  endtask

  task automatic cmp(input string tag, input res_t a, input res_t e);
    chk({tag, " cycles"}, a.cyc, e.cyc);
    chk({tag, " pc_src"}, a.src, e.src);
    chk({tag, " reg_we"}, a.rw, e.rw);
    chk({tag, " wb_sel"}, a.wbs, e.wbs);
    chk({tag, " illegal"}, a.ill, e.ill);
    chk({tag, " mem_we"}, a.mw, e.mw);
    chk({tag, " mem cycles"}, a.memcyc, e.memcyc);
    chk({tag, " alu_op"}, a.alu, e.alu);
    chk({tag, " alu_src"}, a.asrc, e.asrc);
    chk({tag, " flag_z"}, a.fz, e.fz);
    chk({tag, " flag_n"}, a.fn, e.fn);
    chk({tag, " bus_err"}, a.be, e.be);
    chk({tag, " ir_we"}, a.irwe, e.irwe);
  endtask

  vec_t tv[15];
  res_t o, e;

  initial begin
    // op fd md z n | cyc src rw wbs ill mw memcyc alu asrc fz fn be
    tv[0]  = '{4,  0, 0, 1, 0, mk(4, 0, 1, 0, 0, 0, 0, 4, 0, 1, 0, 0)};
    tv[1]  = '{7,  1, 0, 1, 0, mk(5, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0)};
    tv[2]  = '{9,  0, 0, 0, 0, mk(3, 2, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0)};
    tv[3]  = '{4,  0, 0, 0, 1, mk(4, 0, 1, 0, 0, 0, 0, 4, 0, 0, 1, 0)};
    tv[4]  = '{9,  0, 0, 1, 1, mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)};
    tv[5]  = '{11, 0, 0, 0, 0, mk(3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)};
    tv[6]  = '{14, 0, 3, 1, 0, mk(8, 0, 1, 1, 0, 0, 4, 4, 0, 0, 1, 0)};
    tv[7]  = '{3,  0, 0, 1, 0, mk(4, 0, 0, 0, 0, 1, 1, 4, 0, 0, 1, 0)};
    tv[8]  = '{10, 2, 1, 0, 0, mk(7, 3, 0, 0, 0, 0, 2, 4, 0, 0, 1, 0)};
    tv[9]  = '{1,  0, 0, 1, 0, mk(3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0)};
    tv[10] = '{8,  0, 0, 0, 0, mk(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)};
    tv[11] = '{15, 0, 0, 1, 1, mk(4, 0, 1, 0, 0, 0, 0, 4, 1, 0, 1, 0)};
    tv[12] = '{5,  3, 0, 0, 0, mk(7, 0, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0)};
    tv[13] = '{6,  0, 0, 1, 1, mk(4, 0, 1, 0, 0, 0, 0, 2, 0, 1, 1, 0)};
    tv[14] = '{0,  4, 0, 0, 0, mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1)};

    rst = 1'b1;
    mem_ack = 1'b0;
    inst = 32'h4000_0000;
    z = 1'b0;
    n = 1'b0;
    #1;
    chk("outputs in reset", int'(outs), 0);
    repeat (3) begin
      tick();
      mem_ack = ~mem_ack;
      z = 1'b1;
      n = 1'b1;
      #1;
      chk("outputs held in reset", int'(outs), 0);
    end
    rst = 1'b0;
    mem_ack = 1'b0;
    #1;
    chk("idle outputs", int'(outs), 0);
    tick();
    chk("fetch mem_req", int'(mem_req), 1);
    chk("fetch addr_sel", int'(addr_sel), 0);

    for (int i = 0; i < 15; i++) begin
      run_instr(tv[i].op, tv[i].fd, tv[i].md, tv[i].z, tv[i].n, o);
      cmp($sformatf("vec%0d", i), o, tv[i].e);
      mz = tv[i].e.fz;
      mn = tv[i].e.fn;
    end

    // LD whose MEM phase is never acknowledged: bus error, back to FETCH, no write-back.
    mem_ack = 1'b1;
    inst = 32'hE000_0000;
    tick();
    mem_ack = 1'b0;
    tick();
    tick();
    for (int k = 1; k <= TMO; k++) begin
      chk("mem tmo mem_req", int'(mem_req && addr_sel), 1);
      chk("mem tmo bus_err", int'(bus_err), int'(k == TMO));
      chk("mem tmo pc_we", int'(pc_we || reg_we), 0);
      tick();
    end
    chk("mem tmo refetch", int'(mem_req && !addr_sel && !bus_err), 1);

    e = model(4, 0, 0, 1, 1);
    run_instr(4, 0, 0, 1, 1, o);
    cmp("add before reset", o, e);

    // Reset asserted while an LD waits in MEM.
    mem_ack = 1'b1;
    inst = 32'hE000_0000;
    #1;
    chk("ld fetch ir_we", int'(ir_we), 1);
    tick();
    mem_ack = 1'b0;
    tick();
    tick();
    chk("ld in mem", int'(mem_req && addr_sel), 1);
    rst = 1'b1;
    #1;
    chk("mid-mem reset mem_req", int'(mem_req), 0);
    chk("mid-mem reset flags", int'({flag_z, flag_n}), 0);
    chk("mid-mem reset outputs", int'(outs), 0);
    tick();
    rst = 1'b0;
    #1;
    chk("idle after reset", int'(outs), 0);
    tick();
    chk("fetch after reset", int'(mem_req && !addr_sel), 1);
    mz = 0;
    mn = 0;

    for (int i = 0; i < 200; i++) begin
      int op, fd, md, zz, nn;
      op = $urandom_range(0, 15);
      fd = $urandom_range(0, 5);
      md = $urandom_range(0, 3);
      zz = $urandom_range(0, 1);
      nn = $urandom_range(0, 1);
      e = model(op, fd, md, zz, nn);
      run_instr(op, fd, md, zz, nn, o);
      cmp($sformatf("rnd%0d op%0d", i, op), o, e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Parametrised multi-cycle control unit for the team's 32-bit CPU. Replaces the single-cycle combinational opcode decode.
- Sequences every instruction through FETCH/DECODE/EXEC/MEM/WB over a shared instruction/data memory that uses a req/ack handshake.
- Holds the Z/N condition flags internally, so branches use the flags of the last ALU instruction.
- Detects illegal opcodes and memory timeouts.

Parameters:
- IW, 32, instruction width
- OPW, 4, opcode width
- OPLSB, 28, bit position of opcode LSB in inst (opcode = inst[OPLSB+OPW-1:OPLSB])
- TMO, 16, max cycles to wait for mem_ack before bus error (1..255)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- inst  in  IW  memory read data; sampled only in a FETCH cycle with mem_ack=1
- z  in  1  ALU zero result, valid in EXEC
- n  in  1  ALU negative result, valid in EXEC
- mem_ack  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request, held until ack or timeout
- mem_we  out  1  write strobe, qualifies mem_req
- addr_sel  out  1  0 = PC address, 1 = ALU/data address
- ir_we  out  1  load instruction register
- pc_we  out  1  update PC
- pc_src  out  2  0 = PC+1, 1 = jump target, 2 = branch target, 3 = memory data
- reg_we  out  1  register file write
- wb_sel  out  1  0 = ALU result, 1 = memory data
- alu_src  out  1  1 = immediate/PC operand
- alu_op  out  3  ALU operation
- flag_z  out  1  stored Z flag
- flag_n  out  1  stored N flag
- illegal  out  1  one-cycle pulse on undefined opcode
- bus_err  out  1  one-cycle pulse on memory timeout

Behaviour:
- Opcodes: NOP 0, ST 3, ADD 4, ADDI 5, NEG 6, SUB 7, J 8, BRZ 9, JM A, BRN B, LD E, SVPC F. All other values are illegal.
- alu_op encodings: ADD/ADDI/SVPC = 100, NEG = 010, SUB = 001. alu_src = 1 for ADDI and SVPC.
- Outputs are combinational from the state and the internal opcode register op_q. When not driven they are 0.
- Reset: state = IDLE, op_q = 0, flag_z = flag_n = 0, timeout counter = 0. All outputs are 0 while rst is high. IDLE moves to FETCH on the first clock edge after release.
- Reset asserted mid-instruction aborts immediately. A pending mem_req drops asynchronously.
- FETCH: mem_req = 1, addr_sel = 0.
  - On mem_ack: ir_we = 1, op_q <= opcode(inst), next state DECODE.
- DECODE: one cycle, no strobes. Next state EXEC.
- EXEC: alu_op and alu_src are driven for ALU ops, SVPC, LD, ST and JM.
  - ADD/ADDI/NEG/SUB: flags <= {z, n} at the EXEC clock edge. Next state WB.
  - SVPC: next state WB. Flags are unchanged.
  - J: pc_we = 1, pc_src = 1. Next state FETCH.
  - BRZ/BRN: pc_we = 1, pc_src = 2 if flag_z (BRZ) or flag_n (BRN) is set, else pc_src = 0. Next state FETCH.
  - NOP: pc_we = 1, pc_src = 0. Next state FETCH.
  - Illegal opcode: illegal = 1 and NOP behaviour.
  - LD/ST/JM: next state MEM.
- MEM: mem_req = 1, addr_sel = 1, mem_we = 1 for ST only.
  - On mem_ack with ST: pc_we = 1, pc_src = 0, next state FETCH.
  - On mem_ack with JM: pc_we = 1, pc_src = 3, next state FETCH.
  - On mem_ack with LD: next state WB.
- WB: reg_we = 1, wb_sel = 1 for LD else 0, pc_we = 1, pc_src = 0. Next state FETCH.
- Latencies with zero-wait memory (ack in the first request cycle):
  - J/BR/NOP = 3 cycles
  - ALU/SVPC = 4 cycles
  - ST/JM = 4 cycles
  - LD = 5 cycles
- Each wait state adds 1 cycle.
- Timeout:
  - Counter clears on entry to FETCH or MEM and increments each request cycle without ack.
  - On the TMO-th consecutive unacknowledged cycle: bus_err = 1, mem_req drops next cycle, next state FETCH with no pc_we. A FETCH timeout therefore retries the same PC.
  - mem_ack on the same cycle the count reaches TMO wins: no bus_err.
- mem_ack outside FETCH/MEM is ignored.
- Flags change only on an ALU-op EXEC edge.

Decomposition:
- Package mc_pkg holds:
  - the opcode constants
  - the pc_src and alu_op encodings
  - the state enum: IDLE, FETCH, DECODE, EXEC, MEM, WB
- Sub-module mc_tmo: timeout counter with clear/enable inputs and an expired output, width = clog2(TMO+1).
- Decode and FSM stay in mc_ctrl.

Test Plan:
- Reset then ADD, inst = 0x4000_0000, mem_ack held high:
  - FETCH ack: ir_we.
  - EXEC with z = 1: alu_op = 100, flag_z = 1 after the edge.
  - WB: reg_we = 1 and pc_we = 1, pc_src = 0, exactly 4 cycles after FETCH entry.
- BRZ 0x9000_0000 after SUB with z = 1: EXEC pc_we = 1, pc_src = 2. Repeat with flag_z = 0: pc_src = 0.
- LD 0xE000_0000 with mem_ack delayed 3 cycles in MEM:
  - mem_req = 1 and addr_sel = 1 for 4 cycles, mem_we = 0.
  - Then WB with reg_we = 1, wb_sel = 1.
  - Total 8 cycles.
- ST 0x3000_0000:
  - MEM mem_we = 1.
  - On ack: pc_we = 1, pc_src = 0, no reg_we.
- TMO = 4, mem_ack never asserted in FETCH: bus_err pulse on cycle 4, re-enter FETCH, pc_we never asserted. Separately, ack on cycle 4: no bus_err.
- Opcode 0x1: one-cycle illegal pulse in EXEC, pc_we with pc_src = 0. Assert rst mid-MEM: mem_req = 0 immediately, IDLE, flags cleared.
